// File: rtl/jt49_bus_master.sv
// rtl/jt49_bus_master.sv - BDIR/BC1 bus-cycle initiator for AY-3-8910 style responders
module jt49_bus_master #(
  parameter int          HOLD      = 2,
  parameter logic [3:0]  CHIP_ADDR = 4'h0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req,
  input  logic       we,
  input  logic [3:0] reg_addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       bdir,
  output logic       bc1,
  output logic [7:0] bus_dout,
  output logic       bus_oe,
  input  logic [7:0] bus_din
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_GAP1,
    S_ACCESS,
    S_GAP2
  } state_t;

  localparam logic [3:0] LAST = 4'(HOLD - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        bdir_q, bdir_d;
  logic        bc1_q, bc1_d;
  logic [7:0]  bus_dout_q, bus_dout_d;
  logic        bus_oe_q, bus_oe_d;

  // Outputs are computed for the state being entered, so every pin is a flop.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    rdata_d    = rdata_q;
    bdir_d     = bdir_q;
    bc1_d      = bc1_q;
    bus_dout_d = bus_dout_q;
    bus_oe_d   = bus_oe_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          we_d       = we;
          wdata_d    = wdata;
          state_d    = S_LATCH;
          cnt_d      = 4'd0;
          busy_d     = 1'b1;
          bdir_d     = 1'b1;
          bc1_d      = 1'b1;
          bus_dout_d = {CHIP_ADDR, reg_addr};
          bus_oe_d   = 1'b1;
        end
      end
      S_LATCH: begin
        if (cnt_q == LAST) begin
          state_d  = S_GAP1;
          cnt_d    = 4'd0;
          bdir_d   = 1'b0;
          bc1_d    = 1'b0;
          bus_oe_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_GAP1: begin
        state_d = S_ACCESS;
        cnt_d   = 4'd0;
        if (we_q) begin
          bdir_d     = 1'b1;
          bus_dout_d = wdata_q;
          bus_oe_d   = 1'b1;
        end else begin
          bc1_d = 1'b1;
        end
      end
      S_ACCESS: begin
        if (cnt_q == LAST) begin
          // Read data has had HOLD cycles to settle; capture on the final strobe cycle.
          if (!we_q) rdata_d = bus_din;
          state_d  = S_GAP2;
          cnt_d    = 4'd0;
          bdir_d   = 1'b0;
          bc1_d    = 1'b0;
          bus_oe_d = 1'b0;
          done_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_GAP2: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d  = S_IDLE;
        busy_d   = 1'b0;
        bdir_d   = 1'b0;
        bc1_d    = 1'b0;
        bus_oe_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      we_q       <= 1'b0;
      wdata_q    <= 8'h00;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rdata_q    <= 8'h00;
      bdir_q     <= 1'b0;
      bc1_q      <= 1'b0;
      bus_dout_q <= 8'h00;
      bus_oe_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rdata_q    <= rdata_d;
      bdir_q     <= bdir_d;
      bc1_q      <= bc1_d;
      bus_dout_q <= bus_dout_d;
      bus_oe_q   <= bus_oe_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign rdata    = rdata_q;
  assign bdir     = bdir_q;
  assign bc1      = bc1_q;
  assign bus_dout = bus_dout_q;
  assign bus_oe   = bus_oe_q;

endmodule

// File: tb/tb_jt49_bus_master.sv
// tb/tb_jt49_bus_master.sv - bench for jt49_bus_master with register-file and address-echo responders
module tb_jt49_bus_master;

  logic       clk;
  logic       rst_n;
  logic       req2, req3;
  logic       we;
  logic [3:0] reg_addr;
  logic [7:0] wdata;
  logic       mem_clr;

  logic       busy2, done2, bdir2, bc1_2, oe2;
  logic [7:0] rdata2, dout2, din2;
  logic       busy3, done3, bdir3, bc1_3, oe3;
  logic [7:0] rdata3, dout3, din3;

  int checks = 0;
  int errors = 0;

  jt49_bus_master #(.HOLD(2), .CHIP_ADDR(4'h0)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .req(req2), .we(we), .reg_addr(reg_addr), .wdata(wdata),
    .busy(busy2), .done(done2), .rdata(rdata2), .bdir(bdir2), .bc1(bc1_2),
    .bus_dout(dout2), .bus_oe(oe2), .bus_din(din2)
  );

  jt49_bus_master #(.HOLD(3), .CHIP_ADDR(4'h0)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .req(req3), .we(we), .reg_addr(reg_addr), .wdata(wdata),
    .busy(busy3), .done(done3), .rdata(rdata3), .bdir(bdir3), .bc1(bc1_3),
    .bus_dout(dout3), .bus_oe(oe3), .bus_din(din3)
  );

  always #5 clk = ~clk;

  // Register-file responder: latches address on 11, writes on 10, drives data on 01.
  logic [7:0] mem2 [16];
  logic [3:0] lat2;
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 16; i++) mem2[i] <= 8'h00;
      lat2 <= 4'h0;
    end else if (bdir2 && bc1_2 && dout2[7:4] == 4'h0) begin
      lat2 <= dout2[3:0];
    end else if (bdir2 && !bc1_2) begin
      mem2[lat2] <= dout2;
    end
  end
  assign din2 = (!bdir2 && bc1_2) ? mem2[lat2] : 8'hFF;

  // Echo responder: returns {C, latched address} on reads.
  logic [3:0] lat3;
  always @(posedge clk) begin
    if (mem_clr) lat3 <= 4'h0;
    else if (bdir3 && bc1_3 && dout3[7:4] == 4'h0) lat3 <= dout3[3:0];
  end
  assign din3 = (!bdir3 && bc1_3) ? {4'hC, lat3} : 8'hFF;

  typedef struct packed {
    logic       we;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t       tbl [8];
  logic [7:0] sb [16];
  logic [7:0] last2;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%02h expected=%02h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] ctl(input int sel);
    return (sel != 0) ? {bdir3, bc1_3, oe3, busy3, done3} : {bdir2, bc1_2, oe2, busy2, done2};
  endfunction

  function automatic logic [7:0] dout(input int sel);
    return (sel != 0) ? dout3 : dout2;
  endfunction

  function automatic logic [7:0] rd(input int sel);
    return (sel != 0) ? rdata3 : rdata2;
  endfunction

  task automatic set_req(input int sel, input logic v);
    if (sel != 0) req3 = v;
    else req2 = v;
  endtask

  // Expected pins for cycle k of a transaction, from the phase boundaries in cycle counts.
  task automatic check_cycle(input int sel, input int h, input int k,
                             input logic w, input logic [3:0] a, input logic [7:0] d);
    logic [4:0] e;
    logic [7:0] ed;
    logic       cd;
    ed = {4'h0, a};
    cd = 1'b0;
    if (k <= h) begin
      e = 5'b11110; cd = 1'b1;
    end else if (k == h + 1) begin
      e = 5'b00010; cd = 1'b1;
    end else if (k <= 2 * h + 1) begin
      if (w) begin
        e = 5'b10110; ed = d; cd = 1'b1;
      end else begin
        e = 5'b01010;
      end
    end else if (k == 2 * h + 2) begin
      e = 5'b00011;
    end else begin
      e = 5'b00000;
    end
    chk($sformatf("ctl{bdir,bc1,oe,busy,done} d%0d c%0d", sel, k), {3'b000, ctl(sel)}, {3'b000, e});
    if (cd) chk($sformatf("bus_dout d%0d c%0d", sel, k), dout(sel), ed);
  endtask

  task automatic run_txn(input int sel, input logic w, input logic [3:0] a, input logic [7:0] d,
                         input logic hold, input logic [7:0] exp_rd);
    int h;
    h = (sel != 0) ? 3 : 2;
    set_req(sel, 1'b1);
    we = w; reg_addr = a; wdata = d;
    step();
    for (int k = 1; k <= 2 * h + 3; k++) begin
      check_cycle(sel, h, k, w, a, d);
      if (k == 2 * h + 2) chk($sformatf("rdata at done d%0d", sel), rd(sel), exp_rd);
      if (k == 2 * h + 3) begin
        if (!hold) set_req(sel, 1'b0);
      end else begin
        if (hold) begin
          if (k == 3) begin
            we = 1'b0; reg_addr = 4'd9; wdata = 8'hAA;
          end else if (k >= 4) begin
            we = 1'b1; reg_addr = 4'd4; wdata = 8'h66;
          end
        end else begin
          set_req(sel, 1'($urandom));
          we = 1'($urandom); reg_addr = 4'($urandom); wdata = 8'($urandom);
        end
        step();
      end
    end
  endtask

  initial begin
    logic       w;
    logic [3:0] a;
    logic [7:0] d;
    logic [7:0] e;
    clk = 1'b0; rst_n = 1'b0; req2 = 1'b0; req3 = 1'b0;
    we = 1'b0; reg_addr = 4'h0; wdata = 8'h00; mem_clr = 1'b1;
    for (int i = 0; i < 16; i++) sb[i] = 8'h00;
    tbl[0] = {1'b1, 4'd1, 8'h0F, 8'h00};
    tbl[1] = {1'b0, 4'd1, 8'h00, 8'h0F};
    tbl[2] = {1'b1, 4'd8, 8'h1F, 8'h0F};
    tbl[3] = {1'b0, 4'd8, 8'h00, 8'h1F};
    tbl[4] = {1'b1, 4'd7, 8'h38, 8'h1F};
    tbl[5] = {1'b0, 4'd7, 8'h00, 8'h38};
    tbl[6] = {1'b1, 4'd3, 8'h5A, 8'h38};
    tbl[7] = {1'b0, 4'd3, 8'h00, 8'h5A};

    step(); step();
    mem_clr = 1'b0;
    chk("reset ctl d2", {3'b000, ctl(0)}, 8'h00);
    chk("reset ctl d3", {3'b000, ctl(1)}, 8'h00);
    chk("reset rdata d2", rdata2, 8'h00);
    chk("reset rdata d3", rdata3, 8'h00);
    chk("reset bus_dout d2", dout2, 8'h00);
    chk("reset bus_dout d3", dout3, 8'h00);

    req2 = 1'b1; we = 1'b1; reg_addr = 4'd5;
    step();
    chk("reset beats req", {3'b000, ctl(0)}, 8'h00);
    req2 = 1'b0; rst_n = 1'b1;
    step();
    chk("idle after reset+req", {3'b000, ctl(0)}, 8'h00);

    last2 = 8'h00;
    for (int i = 0; i < 8; i++) begin
      run_txn(0, tbl[i].we, tbl[i].addr, tbl[i].wdata, 1'b0, tbl[i].exp_rd);
      if (tbl[i].we) sb[tbl[i].addr] = tbl[i].wdata;
      else last2 = tbl[i].exp_rd;
    end

    run_txn(0, 1'b1, 4'd2, 8'h44, 1'b1, last2);
    sb[2] = 8'h44;
    run_txn(0, 1'b1, 4'd4, 8'h66, 1'b0, last2);
    sb[4] = 8'h66;
    chk("pulsed read never ran", rdata2, last2);

    // Write of reg 7 (same value as held) interrupted by reset in its first access cycle.
    req2 = 1'b1; we = 1'b1; reg_addr = 4'd7; wdata = 8'h38;
    step();
    req2 = 1'b0;
    step(); step(); step();
    chk("mid write c4 ctl", {3'b000, ctl(0)}, 8'b000_10110);
    rst_n = 1'b0;
    step();
    chk("mid reset c5 ctl", {3'b000, ctl(0)}, 8'h00);
    chk("mid reset c5 rdata", rdata2, 8'h00);
    rst_n = 1'b1;
    step();
    chk("mid reset c6 no done", {3'b000, ctl(0)}, 8'h00);
    run_txn(0, 1'b0, 4'd7, 8'h00, 1'b0, sb[7]);
    last2 = sb[7];

    for (int n = 0; n < 24; n++) begin
      w = 1'($urandom); a = 4'($urandom); d = 8'($urandom);
      e = w ? last2 : sb[a];
      run_txn(0, w, a, d, 1'b0, e);
      if (w) sb[a] = d;
      else last2 = sb[a];
    end

    run_txn(1, 1'b0, 4'd14, 8'h00, 1'b0, 8'hCE);
    run_txn(1, 1'b1, 4'd6, 8'h99, 1'b0, 8'hCE);
    run_txn(1, 1'b0, 4'd3, 8'h00, 1'b0, 8'hC3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jt49_bus_master.md
# jt49_bus_master

Bus-side initiator for the BDIR/BC1 interface of the AY-3-8910 family. It turns a simple request (register number, read/write, write data) into the original chip's bus-cycle sequence: latch address, inactive gap, write or read strobe, inactive gap. It sits between a host or CPU-side controller and a jt49 core wrapped with BDIR/BC1 pins, or real silicon driven through FPGA pins. Read data is captured from the chip's data bus and returned with a completion pulse.

## Interface
- HOLD, 2: clk cycles each active bus phase (latch, write, read) is held; legal range 2..15.
- CHIP_ADDR, 4'h0: value driven on bus_dout[7:4] during address latch; the responder decodes upper nibble 0 as selected.
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req  in  1  request strobe; sampled only while idle.
- we  in  1  1 = register write, 0 = register read; sampled with req.
- reg_addr  in  4  PSG register number 0..15; sampled with req.
- wdata  in  8  write data; sampled with req.
- busy  out  1  high from the cycle after acceptance through the final gap cycle.
- done  out  1  one-cycle pulse in the final gap cycle.
- rdata  out  8  last read result; held until the next read completes.
- bdir  out  1  BDIR pin.
- bc1  out  1  BC1 pin.
- bus_dout  out  8  data/address driven to the chip.
- bus_oe  out  1  1 while bus_dout must be driven (latch and write phases).
- bus_din  in  8  data returned by the chip.

## Operation
- States: IDLE, LATCH, GAP1, ACCESS, GAP2. A 4-bit phase counter counts HOLD cycles.
- IDLE: {bdir,bc1}=00, bus_oe=0. If req=1, capture we, reg_addr and wdata, then go to LATCH.
- LATCH, HOLD cycles: {bdir,bc1}=11, bus_dout={CHIP_ADDR,reg_addr}, bus_oe=1. Then go to GAP1.
- GAP1, 1 cycle: {bdir,bc1}=00, bus_oe=0, bus_dout holds its value. Then go to ACCESS.
- ACCESS, HOLD cycles:
  - Write: {bdir,bc1}=10, bus_dout=captured wdata, bus_oe=1.
  - Read: {bdir,bc1}=01, bus_oe=0; bus_din is sampled into rdata on the last ACCESS cycle.
  - Then go to GAP2.
- GAP2, 1 cycle: {bdir,bc1}=00, bus_oe=0, done=1. Then go to IDLE.
- Captured request fields are frozen for the whole transaction; input changes while busy have no effect.
- req while busy is ignored and not queued. The host must re-present it after done.
- Writes never modify rdata.
- The 11 and 10 encodings are never adjacent: a 00 gap always separates phases, so the responder never sees a spurious address latch.

## Timing
- Reset values: bdir=0, bc1=0, bus_dout=8'h00, bus_oe=0, busy=0, done=0, rdata=8'h00, state IDLE.
- All outputs are registered.
- Cycle 0 is the cycle in which req=1 is sampled in IDLE.
  - Cycles 1..HOLD: LATCH.
  - Cycle HOLD+1: GAP1.
  - Cycles HOLD+2..2·HOLD+1: ACCESS.
  - Cycle 2·HOLD+2: GAP2, with done=1.
- Transaction latency is 2·HOLD+2 cycles. With HOLD=2, done is high in cycle 6.
- busy is high in cycles 1..2·HOLD+2 and low in cycle 2·HOLD+3. The earliest next acceptance is cycle 2·HOLD+3, so back-to-back transactions have period 2·HOLD+3.
- rdata updates at the end of cycle 2·HOLD+1 and is valid while done=1.
- HOLD>=2 is required because the responder registers BDIR/BC1 one cycle, and its read data must settle before sampling.
- Reset asserted mid-transaction: at the next edge all outputs take reset values and the state is IDLE. No done pulse is produced, and rdata is cleared.
- Reset and req both high: reset wins; nothing is accepted.

## Test plan
- Write, HOLD=2: req, we=1, reg_addr=7, wdata=8'h38 → cycles 1–2 {bdir,bc1}=11 with bus_dout=8'h07; cycle 3 = 00; cycles 4–5 = 10 with bus_dout=8'h38; cycle 6 = 00 with done=1; busy low in cycle 7.
- Read against a model returning 8'h5A during 01 → rdata=8'h5A when done pulses in cycle 6; bus_oe=0 throughout the read phase.
- Loopback to a BDIR/BC1-wrapped jt49: write reg 1 = 8'h0F, then read reg 1 → rdata=8'h0F. Write reg 8 = 8'h1F, then read reg 8 → 8'h1F.
- req held high, plus a second req pulse in cycle 3 with different fields → the first transaction completes with its original fields. The held req is re-accepted in cycle 7, and the pulsed request is never executed.
- rst_n low in cycle 4 of a write → cycle 5 shows {bdir,bc1}=00, busy=0, bus_oe=0; no done pulse; the DUT accepts a new req in cycle 6.
- HOLD=3, CHIP_ADDR=4'h0, read of reg 14 → latch for 3 cycles with bus_dout=8'h0E; done in cycle 8.
